// File: rtl/ex_logic_pkg.sv
// Shared op codes, FSM states and shift helpers for the EX logic/compare/shift unit.
// Defining LOGIC_ROTATE_EN turns LOP_ROTR into a real rotate; otherwise it decodes as undefined.
package ex_logic_pkg;

  localparam logic [3:0] LOP_OR   = 4'd0;
  localparam logic [3:0] LOP_AND  = 4'd1;
  localparam logic [3:0] LOP_XOR  = 4'd2;
  localparam logic [3:0] LOP_NOR  = 4'd3;
  localparam logic [3:0] LOP_PASS = 4'd4;
  localparam logic [3:0] LOP_SLT  = 4'd5;
  localparam logic [3:0] LOP_SLTU = 4'd6;
  localparam logic [3:0] LOP_SLL  = 4'd7;
  localparam logic [3:0] LOP_SRL  = 4'd8;
  localparam logic [3:0] LOP_SRA  = 4'd9;
  localparam logic [3:0] LOP_ROTR = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SM_SLL  = 2'd0,
    SM_SRL  = 2'd1,
    SM_SRA  = 2'd2,
    SM_ROTR = 2'd3
  } shift_mode_e;

  function automatic logic is_shift_op(input logic [3:0] op);
`ifdef LOGIC_ROTATE_EN
    return (op == LOP_SLL) || (op == LOP_SRL) || (op == LOP_SRA) || (op == LOP_ROTR);
`else
    return (op == LOP_SLL) || (op == LOP_SRL) || (op == LOP_SRA);
`endif
  endfunction

  function automatic shift_mode_e shift_mode_of(input logic [3:0] op);
    shift_mode_e m;
    case (op)
      LOP_SLL: m = SM_SLL;
      LOP_SRL: m = SM_SRL;
      LOP_SRA: m = SM_SRA;
      default: m = SM_ROTR;
    endcase
    return m;
  endfunction

  // Bits needed for one bounded step amount: min(SHIFT_STEP, DATA_WIDTH-1).
  function automatic int step_amt_width(input int dw, input int ss);
    return (ss >= dw) ? $clog2(dw) : $clog2(ss) + 1;
  endfunction

endpackage

// File: rtl/logic_shift_step.sv
// One bounded shift/rotate step: a small barrel whose stage count only covers
// amounts up to SHIFT_STEP, so the unit iterates instead of shifting in one go.
module logic_shift_step
  import ex_logic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 8,
  localparam int STW = step_amt_width(DATA_WIDTH, SHIFT_STEP)
) (
  input  logic [DATA_WIDTH-1:0] in_value,
  input  logic [STW-1:0]        amt,
  input  shift_mode_e           mode,
  input  logic                  fill,
  output logic [DATA_WIDTH-1:0] out_value
);

  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  logic [DATA_WIDTH-1:0] stage_v [STW+1];

  assign stage_v[0] = in_value;

  for (genvar gi = 0; gi < STW; gi++) begin : g_stage
    localparam int S = 1 << gi;
    logic [DATA_WIDTH-1:0] sl, sr, sa, ro;

    assign sl = stage_v[gi] << S;
    assign sr = stage_v[gi] >> S;
    assign sa = fill ? (sr | ~(ONES >> S)) : sr;
    assign ro = sr | (stage_v[gi] << (DATA_WIDTH - S));

    assign stage_v[gi+1] = !amt[gi]          ? stage_v[gi] :
                           (mode == SM_SLL)  ? sl :
                           (mode == SM_SRL)  ? sr :
                           (mode == SM_SRA)  ? sa : ro;
  end

  assign out_value = stage_v[STW];

endmodule

// File: rtl/ex_logic_shift_unit.sv
// EX-stage logic/compare/shift unit: single-cycle bitwise/compare ops, iterative shifts.
// Build with LOGIC_ROTATE_EN to add LOP_ROTR (rotate right by shamt).
module ex_logic_shift_unit
  import ex_logic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 8,
  localparam int SHW = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [SHW-1:0]        in_shamt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  busy
);

  localparam int STW = step_amt_width(DATA_WIDTH, SHIFT_STEP);
  localparam logic [SHW:0] STEP_W = (SHW+1)'(SHIFT_STEP);

  state_e                state_q, state_d;
  logic [SHW-1:0]        rem_q, rem_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  shift_mode_e           mode_q, mode_d;
  logic                  fill_q, fill_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic                  accept;
  logic [SHW-1:0]        step_rem;
  logic [DATA_WIDTH-1:0] step_out;
  logic [DATA_WIDTH-1:0] imm_result;
  logic [DATA_WIDTH-1:0] diff;
  logic                  slt_bit;

  assign in_ready   = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign out_result = result_q;

  // When rem exceeds SHIFT_STEP, SHIFT_STEP itself is < DATA_WIDTH and fits in SHW bits.
  assign step_rem = ({1'b0, rem_q} > STEP_W) ? STEP_W[SHW-1:0] : rem_q;

  logic_shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_step (
    .in_value  (acc_q),
    .amt       (step_rem[STW-1:0]),
    .mode      (mode_q),
    .fill      (fill_q),
    .out_value (step_out)
  );

  // Differing signs decide SLT directly, so the subtract MSB is only trusted when it cannot overflow.
  always_comb begin
    diff       = in_a - in_b;
    slt_bit    = (in_a[DATA_WIDTH-1] ^ in_b[DATA_WIDTH-1]) ? in_a[DATA_WIDTH-1] : diff[DATA_WIDTH-1];
    imm_result = '0;
    case (in_op)
      LOP_OR:   imm_result = in_a | in_b;
      LOP_AND:  imm_result = in_a & in_b;
      LOP_XOR:  imm_result = in_a ^ in_b;
      LOP_NOR:  imm_result = ~(in_a | in_b);
      LOP_PASS: imm_result = in_a | in_b;
      LOP_SLT:  imm_result = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
      LOP_SLTU: imm_result = {{(DATA_WIDTH-1){1'b0}}, (in_a < in_b)};
      LOP_SLL, LOP_SRL, LOP_SRA: imm_result = in_b;
`ifdef LOGIC_ROTATE_EN
      LOP_ROTR: imm_result = in_b;
`endif
      default:  imm_result = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    fill_d   = fill_q;
    result_d = result_q;
    unique case (state_q)
      ST_SHIFT: begin
        acc_d = step_out;
        rem_d = rem_q - step_rem;
        if (rem_d == '0) begin
          state_d  = ST_DONE;
          result_d = step_out;
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: ;
    endcase
    if (accept) begin
      if (is_shift_op(in_op) && (in_shamt != '0)) begin
        state_d = ST_SHIFT;
        rem_d   = in_shamt;
        acc_d   = in_b;
        mode_d  = shift_mode_of(in_op);
        fill_d  = in_b[DATA_WIDTH-1];
      end else begin
        state_d  = ST_DONE;
        result_d = imm_result;
      end
    end
    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      acc_q    <= '0;
      mode_q   <= SM_SLL;
      fill_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_ex_logic_shift_unit.sv
// Bench for ex_logic_shift_unit: three instances (SHIFT_STEP 1, 8, 32) checked
// against an arithmetic reference model; directed scenarios run on the SHIFT_STEP=8 copy.
`timescale 1ns/1ps
module tb_ex_logic_shift_unit;
  import ex_logic_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [3:0]   in_op;
  logic [W-1:0] in_a, in_b;
  logic [4:0]   in_shamt;
  logic [2:0]   in_valid_w, out_ready_w, in_ready_w, out_valid_w, busy_w;
  logic [W-1:0] res_w [3];

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    ex_logic_shift_unit #(
      .DATA_WIDTH (W),
      .SHIFT_STEP ((gi == 0) ? 1 : ((gi == 1) ? 8 : 32))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid_w[gi]),
      .in_ready   (in_ready_w[gi]),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_shamt   (in_shamt),
      .out_valid  (out_valid_w[gi]),
      .out_ready  (out_ready_w[gi]),
      .out_result (res_w[gi]),
      .busy       (busy_w[gi])
    );
  end

  function automatic int step_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 8 : 32);
  endfunction

  function automatic bit model_is_shift(input logic [3:0] op);
`ifdef LOGIC_ROTATE_EN
    if (op == LOP_ROTR) return 1'b1;
`endif
    return (op == LOP_SLL) || (op == LOP_SRL) || (op == LOP_SRA);
  endfunction

  function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input int sh);
    logic [63:0] t;
    case (op)
      LOP_OR:   return a | b;
      LOP_AND:  return a & b;
      LOP_XOR:  return a ^ b;
      LOP_NOR:  return ~(a | b);
      LOP_PASS: return a | b;
      LOP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      LOP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      LOP_SLL:  return b << sh;
      LOP_SRL:  return b >> sh;
      LOP_SRA:  return 32'($signed(b) >>> sh);
`ifdef LOGIC_ROTATE_EN
      LOP_ROTR: begin
        t = {b, b} >> sh;
        return t[31:0];
      end
`endif
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input int sh, input int step);
    if (model_is_shift(op) && sh != 0) return 1 + (sh + step - 1) / step;
    return 1;
  endfunction

  // Issue one op on instance k, wait for its result; lat counts negedges from accept to out_valid.
  task automatic do_op(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic rdy,
                       output logic [31:0] res, output int lat, output int bcnt);
    int guard;
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_shamt = sh;
    in_valid_w[k] = 1'b1;
    out_ready_w[k] = rdy;
    #1;
    guard = 0;
    while (!in_ready_w[k] && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) begin
      tests_run++; fails++;
      $display("[TB] FAIL accept_timeout dut%0d: in_ready stayed 0, required 1", k);
    end
    @(posedge clk);
    lat = 0; bcnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (lat == 0) in_valid_w[k] = 1'b0;
      lat++;
      if (busy_w[k]) bcnt++;
      if (out_valid_w[k]) break;
    end
    res = res_w[k];
    if (!out_valid_w[k]) begin
      tests_run++; fails++;
      $display("[TB] FAIL result_timeout dut%0d: out_valid=0 after %0d cycles, required 1", k, lat);
    end
    $display("[TB] dut%0d op=%0h a=%08h b=%08h sh=%0d -> res=%08h lat=%0d", k, op, a, b, sh, res, lat);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (out_valid_w[k] !== 1'b0 || busy_w[k] !== 1'b0 || res_w[k] !== 32'd0 || in_ready_w[k] !== 1'b1) begin
        fails++;
        $display("[TB] FAIL reset dut%0d: valid=%b busy=%b res=%08h rdy=%b, required 0 0 00000000 1",
                 k, out_valid_w[k], busy_w[k], res_w[k], in_ready_w[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_logic();
    logic [31:0] r, a, b, e;
    int lat, bc;
    logic [3:0] ops [5];
    ops[0] = LOP_OR; ops[1] = LOP_AND; ops[2] = LOP_XOR; ops[3] = LOP_NOR; ops[4] = LOP_PASS;
    do_op(1, LOP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 1'b1, r, lat, bc);
    tests_run++;
    if (r !== 32'hF000F000 || lat != 1) begin
      fails++;
      $display("[TB] FAIL and_example: res=%08h lat=%0d, required F000F000 lat=1", r, lat);
    end
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom;
      e = model_result(ops[i], a, b, 0);
      do_op(1, ops[i], a, b, 5'($urandom_range(0, 31)), 1'b1, r, lat, bc);
      tests_run++;
      if (r !== e || lat != 1) begin
        fails++;
        $display("[TB] FAIL logic_op%0h: res=%08h lat=%0d, required %08h lat=1", ops[i], r, lat, e);
      end
    end
    do_op(1, 4'hF, 32'hFFFFFFFF, 32'h12345678, 5'd3, 1'b1, r, lat, bc);
    tests_run++;
    if (r !== 32'd0 || lat != 1) begin
      fails++;
      $display("[TB] FAIL undefined_op: res=%08h lat=%0d, required 00000000 lat=1", r, lat);
    end
  endtask

  task automatic test_compare();
    logic [31:0] r;
    int lat, bc;
    do_op(1, LOP_SLT, 32'h7FFFFFFF, 32'h80000000, 5'd0, 1'b1, r, lat, bc);
    tests_run++;
    if (r !== 32'd0) begin
      fails++; $display("[TB] FAIL slt_overflow: res=%08h, required 00000000", r);
    end
    do_op(1, LOP_SLT, 32'h80000000, 32'h00000001, 5'd0, 1'b1, r, lat, bc);
    tests_run++;
    if (r !== 32'd1) begin
      fails++; $display("[TB] FAIL slt_neg: res=%08h, required 00000001", r);
    end
    do_op(1, LOP_SLTU, 32'h80000000, 32'h00000001, 5'd0, 1'b1, r, lat, bc);
    tests_run++;
    if (r !== 32'd0) begin
      fails++; $display("[TB] FAIL sltu: res=%08h, required 00000000", r);
    end
  endtask

  task automatic test_shift();
    logic [31:0] r;
    int lat, bc;
    do_op(1, LOP_SRA, 32'hDEADBEEF, 32'h80000000, 5'd31, 1'b1, r, lat, bc);
    tests_run++;
    if (r !== 32'hFFFFFFFF || lat != 5 || bc != 5) begin
      fails++;
      $display("[TB] FAIL sra31: res=%08h lat=%0d busy=%0d, required FFFFFFFF lat=5 busy=5", r, lat, bc);
    end
    @(negedge clk);
    tests_run++;
    if (busy_w[1] !== 1'b0) begin
      fails++; $display("[TB] FAIL sra31_idle: busy=%b, required 0", busy_w[1]);
    end
    do_op(1, LOP_SLL, 32'h0, 32'hA5A5_0F0F, 5'd0, 1'b1, r, lat, bc);
    tests_run++;
    if (r !== 32'hA5A50F0F || lat != 1) begin
      fails++; $display("[TB] FAIL sll0: res=%08h lat=%0d, required A5A50F0F lat=1", r, lat);
    end
    do_op(1, LOP_SRL, 32'h0, 32'hF000_0000, 5'd8, 1'b1, r, lat, bc);
    tests_run++;
    if (r !== 32'h00F00000 || lat != 2) begin
      fails++; $display("[TB] FAIL srl8: res=%08h lat=%0d, required 00F00000 lat=2", r, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, held;
    int lat, bc;
    do_op(1, LOP_AND, 32'h0FF0_1234, 32'hFFFF_00FF, 5'd0, 1'b0, r, lat, bc);
    held = r;
    tests_run++;
    if (held !== 32'h0FF00034) begin
      fails++; $display("[TB] FAIL bp_result: res=%08h, required 0FF00034", held);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid_w[1] !== 1'b1 || res_w[1] !== held || in_ready_w[1] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL bp_hold%0d: valid=%b res=%08h rdy=%b, required 1 %08h 0",
                 i, out_valid_w[1], res_w[1], in_ready_w[1], held);
      end
    end
    in_op = LOP_XOR; in_a = 32'h1111_2222; in_b = 32'h0F0F_0F0F; in_shamt = 5'd0;
    in_valid_w[1] = 1'b1; out_ready_w[1] = 1'b1;
    #1;
    tests_run++;
    if (in_ready_w[1] !== 1'b1) begin
      fails++; $display("[TB] FAIL b2b_ready: in_ready=%b, required 1", in_ready_w[1]);
    end
    @(negedge clk);
    in_valid_w[1] = 1'b0;
    tests_run++;
    if (out_valid_w[1] !== 1'b1 || res_w[1] !== 32'h1E1E2D2D) begin
      fails++;
      $display("[TB] FAIL b2b_result: valid=%b res=%08h, required 1 1E1E2D2D", out_valid_w[1], res_w[1]);
    end
    $display("[TB] dut1 back-to-back xor -> res=%08h", res_w[1]);
    @(negedge clk);
    tests_run++;
    if (out_valid_w[1] !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_drain: valid=%b, required 0", out_valid_w[1]);
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, r;
    int lat, bc;
    prev = res_w[1];
    @(negedge clk);
    in_op = LOP_SLL; in_a = 32'h0; in_b = 32'h0000_0ABC; in_shamt = 5'd20;
    in_valid_w[1] = 1'b1; out_ready_w[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_w[1] = 1'b0;
    tests_run++;
    if (busy_w[1] !== 1'b1) begin
      fails++; $display("[TB] FAIL flush_busy: busy=%b, required 1", busy_w[1]);
    end
    @(negedge clk);
    flush = 1'b1;
    in_valid_w[0] = 1'b1;
    #1;
    tests_run++;
    if (in_ready_w !== 3'b000) begin
      fails++; $display("[TB] FAIL flush_ready: in_ready=%b, required 000", in_ready_w);
    end
    @(negedge clk);
    flush = 1'b0;
    in_valid_w[0] = 1'b0;
    tests_run++;
    if (busy_w !== 3'b000 || out_valid_w !== 3'b000) begin
      fails++;
      $display("[TB] FAIL flush_abort: busy=%b valid=%b, required 000 000", busy_w, out_valid_w);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid_w[1] !== 1'b0 || res_w[1] !== prev) begin
        fails++;
        $display("[TB] FAIL flush_quiet%0d: valid=%b res=%08h, required 0 %08h", i, out_valid_w[1], res_w[1], prev);
      end
    end
    do_op(1, LOP_SLL, 32'h0, 32'h0000_0ABC, 5'd20, 1'b1, r, lat, bc);
    tests_run++;
    if (r !== 32'hABC00000 || lat != 4) begin
      fails++; $display("[TB] FAIL flush_next: res=%08h lat=%0d, required ABC00000 lat=4", r, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int lat, bc;
    do_op(1, LOP_XOR, 32'h1234_5678, 32'h0, 5'd0, 1'b1, r, lat, bc);
    @(negedge clk);
    in_op = LOP_SRA; in_b = 32'h8000_0000; in_shamt = 5'd31;
    in_valid_w[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_w[1] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid_w[1] !== 1'b0 || busy_w[1] !== 1'b0 || res_w[1] !== 32'd0) begin
      fails++;
      $display("[TB] FAIL reset_mid: valid=%b busy=%b res=%08h, required 0 0 00000000",
               out_valid_w[1], busy_w[1], res_w[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid_w[1] !== 1'b0 || busy_w[1] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_quiet%0d: valid=%b busy=%b, required 0 0", i, out_valid_w[1], busy_w[1]);
      end
    end
  endtask

  task automatic test_rotate();
    logic [31:0] r, e;
    int lat, bc, el;
    for (int k = 0; k < 2; k++) begin
`ifdef LOGIC_ROTATE_EN
      e = 32'h10000000;
      el = (k == 0) ? 5 : 2;
`else
      e = 32'd0;
      el = 1;
`endif
      do_op(k, LOP_ROTR, 32'h0, 32'h0000_0001, 5'd4, 1'b1, r, lat, bc);
      tests_run++;
      if (r !== e || lat != el) begin
        fails++;
        $display("[TB] FAIL rotr dut%0d: res=%08h lat=%0d, required %08h lat=%0d", k, r, lat, e, el);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, e;
    logic [3:0]  op;
    logic [4:0]  sh;
    int lat, bc, el, sel;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 30; i++) begin
        op  = 4'($urandom_range(0, 15));
        a   = $urandom;
        b   = $urandom;
        sel = $urandom_range(0, 3);
        sh  = (sel == 0) ? 5'd0 : ((sel == 1) ? 5'd31 : 5'($urandom_range(1, 30)));
        e   = model_result(op, a, b, int'(sh));
        el  = model_lat(op, int'(sh), step_of(k));
        do_op(k, op, a, b, sh, 1'b1, r, lat, bc);
        tests_run++;
        if (r !== e || lat != el) begin
          fails++;
          $display("[TB] FAIL random dut%0d op=%0h sh=%0d: res=%08h lat=%0d, required %08h lat=%0d",
                   k, op, sh, r, lat, e, el);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    in_valid_w = '0; out_ready_w = '1;
    in_op = '0; in_a = '0; in_b = '0; in_shamt = '0;
    test_reset();
    test_logic();
    test_compare();
    test_shift();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_rotate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
